clk_period_meter: RTL and testbench

//   Measures an asynchronous square wave (e.g. the divided clk_1point5hz output or an

---
 rtl/clk_meter_pkg.sv | 13 +
 rtl/sync_edge_detect.sv | 35 +++
 rtl/clk_period_meter.sv | 114 +++++++++++
 tb/tb_clk_period_meter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the clock period meter.
// FSM state encoding and synchroniser depth limit.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } meter_state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input
// with a one-cycle rising-edge pulse on the synced value.
module sync_edge_detect
  import clk_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse
);

  localparam int STAGES =
    (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [STAGES-1:0] chain;
  logic              sync_d;

  // shift the async input through the chain, keep one delayed copy
  always_ff @(posedge clock) begin
    if (reset) begin
      chain  <= '0;
      sync_d <= 1'b0;
    end else begin
      chain  <= {chain[STAGES-2:0], async_in};
      sync_d <= chain[STAGES-1];
    end
  end

  assign sync_out   = chain[STAGES-1];
  assign rise_pulse = chain[STAGES-1] & ~sync_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of an async square wave
// in clock cycles, one result per input period.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] period_cycles,
  output logic [COUNT_WIDTH-1:0] high_cycles,
  output logic                   period_valid,
  output logic                   timeout
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  meter_state_t           state;
  meter_state_t           state_next;
  logic                   sync;
  logic                   rise;
  logic                   publish;
  logic                   expire;
  logic [COUNT_WIDTH-1:0] per_cnt;
  logic [COUNT_WIDTH-1:0] hi_cnt;
  logic [COUNT_WIDTH-1:0] per_inc;
  logic [COUNT_WIDTH-1:0] hi_inc;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock     (clock),
    .reset     (reset),
    .async_in  (sig_in),
    .sync_out  (sync),
    .rise_pulse(rise)
  );

  assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
  assign hi_inc  = (sync && hi_cnt != CNT_MAX) ? hi_cnt + CNT_ONE : hi_cnt;

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next state; publish on a closing edge, expire on saturation
  always_comb begin
    state_next = state;
    publish    = 1'b0;
    expire     = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: state_next = ARM;
        ARM: begin
          if (rise) state_next = MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            publish = 1'b1;
          end else if (per_cnt == CNT_MAX) begin
            expire     = 1'b1;
            state_next = ARM;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // period and high counters, restarted at every rising edge
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise && state != IDLE) begin
      per_cnt <= CNT_ONE;
      hi_cnt  <= CNT_ONE;
    end else if (state == MEASURE && !expire) begin
      per_cnt <= per_inc;
      hi_cnt  <= hi_inc;
    end else begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end
  end

  // registered results, valid strobe and sticky timeout
  always_ff @(posedge clock) begin
    if (reset) begin
      period_cycles <= '0;
      high_cycles   <= '0;
      period_valid  <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      period_valid <= publish;
      if (publish) begin
        period_cycles <= per_cnt;
        high_cycles   <= hi_cnt;
        timeout       <= 1'b0;
      end else if (expire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with an expected-result
// queue filled as the wave is driven and drained on period_valid.
`timescale 1ns/100ps
module tb_clk_period_meter;
  import clk_meter_pkg::*;

  typedef struct {
    logic [7:0] per;
    logic [7:0] hi;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       sig_in;
  logic [7:0] period_cycles;
  logic [7:0] high_cycles;
  logic       period_valid;
  logic       timeout;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic prev_valid  = 1'b0;

  clk_period_meter #(
    .COUNT_WIDTH(8),
    .SYNC_STAGES(2)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sig_in       (sig_in),
    .period_cycles(period_cycles),
    .high_cycles  (high_cycles),
    .period_valid (period_valid),
    .timeout      (timeout)
  );

  always #1 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #0.3;
  endtask

  // one period starting with a rise; pub queues its result
  task automatic pulse(input int p, input int h, input bit pub);
    exp_t e;
    if (pub) begin
      e.per = 8'(p);
      e.hi  = 8'(h);
      sb.push_back(e);
    end
    sig_in = 1'b1;
    cyc(h);
    sig_in = 1'b0;
    cyc(p - h);
  endtask

  // scoreboard drain and strobe-width check
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (period_valid) begin
        check("single_cycle_valid", 32'(prev_valid), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(period_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("period", 32'(period_cycles), 32'(e.per));
          check("high", 32'(high_cycles), 32'(e.hi));
          check("timeout_clr", 32'(timeout), 32'd0);
        end
      end
      prev_valid = period_valid;
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    cyc(4);
    reset = 1'b0;
    @(negedge clock);
    check("rst_period", 32'(period_cycles), 32'd0);
    check("rst_high", 32'(high_cycles), 32'd0);
    check("rst_valid", 32'(period_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // 20-cycle period, 10 high
    enable = 1'b1;
    cyc(4);
    repeat (5) pulse(20, 10, 1'b1);
    check("t1_pending", 32'(sb.size()), 32'd1);

    // duty change to 16/4
    repeat (4) pulse(16, 4, 1'b1);

    // single rise then held low until saturation
    pulse(300, 10, 1'b0);
    @(negedge clock);
    check("t3_drain", 32'(sb.size()), 32'd0);
    check("t3_timeout", 32'(timeout), 32'd1);
    check("t3_state", 32'(u_dut.state), 32'(ARM));
    check("t3_hold_per", 32'(period_cycles), 32'd16);
    check("t3_hold_hi", 32'(high_cycles), 32'd4);

    // restart wave; second rise publishes and clears timeout
    repeat (2) pulse(20, 10, 1'b1);

    // enable dropped mid-measurement
    sig_in = 1'b1;
    cyc(5);
    @(negedge clock);
    check("t4_timeout", 32'(timeout), 32'd0);
    enable = 1'b0;
    cyc(1);
    @(negedge clock);
    check("t4_state", 32'(u_dut.state), 32'(IDLE));
    check("t4_per", 32'(period_cycles), 32'd20);
    check("t4_hi", 32'(high_cycles), 32'd10);
    check("t4_valid", 32'(period_valid), 32'd0);
    cyc(4);
    sig_in = 1'b0;
    cyc(10);
    check("t4_drain", 32'(sb.size()), 32'd0);
    enable = 1'b1;
    cyc(3);
    repeat (2) pulse(20, 10, 1'b1);

    // reset pulse mid-measurement
    sig_in = 1'b1;
    cyc(6);
    check("t5_drain", 32'(sb.size()), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #0.3;
    reset = 1'b0;
    @(negedge clock);
    check("t5_per", 32'(period_cycles), 32'd0);
    check("t5_hi", 32'(high_cycles), 32'd0);
    check("t5_valid", 32'(period_valid), 32'd0);
    check("t5_timeout", 32'(timeout), 32'd0);
    sig_in = 1'b0;
    enable = 1'b0;
    cyc(6);
    enable = 1'b1;
    cyc(3);

    // fastest wave: one cycle high, one low
    repeat (12) pulse(2, 1, 1'b1);
    pulse(2, 1, 1'b0);
    cyc(6);
    @(negedge clock);
    check("t6_no_x", 32'($isunknown({period_cycles, high_cycles,
                                     period_valid, timeout})), 32'd0);
    check("t6_timeout", 32'(timeout), 32'd0);
    check("t6_drain", 32'(sb.size()), 32'd0);
    check("t6_per", 32'(period_cycles), 32'd2);
    enable = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
